tlb_translator: RTL and testbench
=================================

TLB_TRANSLATOR -- requirements
Module: tlb_translator

Interface
REQ-001 SHALL have parameter TLB_ENTRIES, 4, number of fully-associative TLB entries (power of two, 2..8).
REQ-002 SHALL have parameter VPN_W, 6, virtual page number width.
REQ-003 SHALL have parameter PPN_W, 2, physical page number width.
REQ-004 SHALL have parameter OFFSET_W, 8, page offset width (256-byte pages).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  input  1  CPU request present.
REQ-008 SHALL have port req_ready  output  1  translator accepts a request this cycle.
REQ-009 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-010 SHALL have port req_vaddr  input  14  virtual byte address: VPN [13:8], offset [7:0].
REQ-011 SHALL have port req_wdata  input  32  store data.
REQ-012 SHALL have port tlb_flush  input  1  invalidate all TLB entries.
REQ-013 SHALL have port pt_vpn  output  6  page-table lookup index to memory.
REQ-014 SHALL have port pt_ppn  input  2  physical page number returned by memory page table.
REQ-015 SHALL have port pt_hit  input  1  page-table valid bit for pt_vpn.
REQ-016 SHALL have port out_valid  output  1  translated request present downstream.
REQ-017 SHALL have port out_ready  input  1  downstream accepts translated request.
REQ-018 SHALL have ports out_write (1), out_paddr (10), out_wdata (32), all outputs: translated request, paddr = {PPN, offset}.
REQ-019 SHALL have ports page_fault (output 1, one-cycle pulse) and fault_vpn (output 6, faulting VPN).
REQ-020 SHALL have ports hit_count and miss_count, outputs, 16 bits each, lookup statistics.

Function
REQ-021 FSM states SHALL be IDLE, LOOKUP, WALK, ISSUE, FAULT.
REQ-022 IDLE: req_ready = !tlb_flush; on req_valid && req_ready latch write/vaddr/wdata, go LOOKUP.
REQ-023 tlb_flush in IDLE SHALL clear all valid bits at that edge, accept no request that cycle; tlb_flush in other states SHALL be ignored.
REQ-024 LOOKUP (one cycle): compare latched VPN with every valid entry tag; at most one match; hit -> ISSUE, hit_count+1, mark entry most-recent; miss -> WALK, miss_count+1.
REQ-025 WALK (one cycle): pt_vpn = latched VPN; sample pt_hit/pt_ppn at end of cycle; pt_hit=1 -> write entry (lowest-index invalid entry, else LRU entry), mark most-recent, go ISSUE; pt_hit=0 -> no TLB change, go FAULT.
REQ-026 pt_vpn SHALL hold latched VPN in all states other than IDLE (don't-care but stable in IDLE).
REQ-027 ISSUE: out_valid=1 with out_* stable until out_ready=1; on that edge go IDLE.
REQ-028 FAULT (one cycle): page_fault=1, fault_vpn=latched VPN; no downstream request; go IDLE.
REQ-029 Latency from accepting edge: hit -> out_valid 2 cycles later; miss+page hit -> 3; miss+fault -> page_fault 3 cycles later.
REQ-030 LRU: per-entry age counter, log2(TLB_ENTRIES) bits; accessed entry set to 0, entries with smaller age increment, others unchanged; LRU = entry with age TLB_ENTRIES-1.
REQ-031 Counters SHALL saturate at 16'hFFFF, not wrap.
REQ-032 Only one request in flight; req_ready=0 in all states except IDLE.

Reset
REQ-033 rst_n low SHALL immediately force: state IDLE, all valid bits 0, ages = entry index, counters 0, out_valid 0, page_fault 0, fault_vpn 0, out_paddr/out_wdata/out_write 0.
REQ-034 Reset mid-operation SHALL abandon the in-flight request with no out_valid or page_fault produced.

Structure
REQ-035 Package vm_pkg SHALL hold VPN_W, PPN_W, OFFSET_W defaults and the FSM state enum, shared with memory and cache blocks.
REQ-036 LRU age tracking SHALL be a sub-module tlb_lru (inputs: access valid, accessed index; output: victim index).

Verification
REQ-037 After reset, load vaddr 14'h0134 with pt_hit=1, pt_ppn=2 -> miss_count=1, out_paddr=10'h234 three cycles after accept.
REQ-038 Repeat vaddr 14'h01FF -> hit_count=1, pt_vpn not sampled, out_paddr=10'h2FF two cycles after accept.
REQ-039 Access VPN 5 with pt_hit=0 -> page_fault one-cycle pulse, fault_vpn=5, out_valid never asserted, TLB unchanged.
REQ-040 Fill VPNs 0,1,2,3, touch 0, miss VPN 4 -> entry holding VPN 1 replaced; next access to VPN 1 misses, VPN 0 hits.
REQ-041 Hold out_ready=0 for 5 cycles in ISSUE -> out_* stable, req_ready=0; tlb_flush then in IDLE -> next access to cached VPN misses.
REQ-042 Assert rst_n=0 during WALK -> outputs zero immediately, no page_fault/out_valid after release, counters 0.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared virtual-memory defaults and the translator FSM state encoding.
// Memory and cache blocks import these so page geometry stays consistent.
package vm_pkg;
  localparam int VM_VPN_W    = 6;
  localparam int VM_PPN_W    = 2;
  localparam int VM_OFFSET_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WALK,
    ISSUE,
    FAULT
  } vm_state_e;
endpackage

// File: rtl/tlb_lru.sv
// True-LRU age tracker: the accessed entry becomes age 0, younger entries age by one.
// Victim is the entry at maximum age; the update is applied one cycle after an access.
module tlb_lru
  import vm_pkg::*;
#(
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             access_vld,
  input  logic [IDX_W-1:0] access_idx,
  output logic [IDX_W-1:0] victim_idx
);

  logic [IDX_W-1:0] age_q [ENTRIES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= IDX_W'(i);
    end else if (access_vld) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (IDX_W'(i) == access_idx)
          age_q[i] <= '0;
        else if (age_q[i] < age_q[access_idx])
          age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  // Ages always form a permutation, so exactly one entry sits at the maximum.
  always_comb begin
    victim_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (age_q[i] == IDX_W'(ENTRIES - 1)) victim_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/tlb_translator.sv
// Fully-associative TLB: hit -> out_valid 2 cycles after accept, miss 3, page fault pulse 3.
// One request in flight; req_ready only in IDLE, ISSUE holds out_* until out_ready.
module tlb_translator
  import vm_pkg::*;
#(
  parameter int TLB_ENTRIES = 4,
  parameter int VPN_W       = VM_VPN_W,
  parameter int PPN_W       = VM_PPN_W,
  parameter int OFFSET_W    = VM_OFFSET_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [VPN_W+OFFSET_W-1:0] req_vaddr,
  input  logic [31:0]               req_wdata,
  input  logic                      tlb_flush,
  output logic [VPN_W-1:0]          pt_vpn,
  input  logic [PPN_W-1:0]          pt_ppn,
  input  logic                      pt_hit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_write,
  output logic [PPN_W+OFFSET_W-1:0] out_paddr,
  output logic [31:0]               out_wdata,
  output logic                      page_fault,
  output logic [VPN_W-1:0]          fault_vpn,
  output logic [15:0]               hit_count,
  output logic [15:0]               miss_count
);

  localparam int IDX_W = $clog2(TLB_ENTRIES);

  vm_state_e                 state_q;
  logic                      write_q;
  logic [VPN_W+OFFSET_W-1:0] vaddr_q;
  logic [31:0]               wdata_q;
  logic [TLB_ENTRIES-1:0]    valid_q;
  logic [VPN_W-1:0]          tag_q [TLB_ENTRIES];
  logic [PPN_W-1:0]          ppn_q [TLB_ENTRIES];
  logic [15:0]               hit_cnt_q, miss_cnt_q;
  logic [15:0]               hit_cnt_d, miss_cnt_d;
  logic                      out_valid_q, out_write_q, page_fault_q;
  logic [PPN_W+OFFSET_W-1:0] out_paddr_q;
  logic [31:0]               out_wdata_q;
  logic [VPN_W-1:0]          fault_vpn_q;

  logic [VPN_W-1:0]    vpn;
  logic [OFFSET_W-1:0] offset;
  logic                lu_hit, any_free;
  logic [IDX_W-1:0]    lu_idx, free_idx, victim_idx, alloc_idx;
  logic                lru_vld;
  logic [IDX_W-1:0]    lru_idx;

  assign vpn    = vaddr_q[VPN_W+OFFSET_W-1:OFFSET_W];
  assign offset = vaddr_q[OFFSET_W-1:0];

  always_comb begin
    lu_hit = 1'b0;
    lu_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (valid_q[i] && tag_q[i] == vpn) begin
        lu_hit = 1'b1;
        lu_idx = IDX_W'(i);
      end
    end
  end

  // Descending scan leaves the lowest-index free slot selected.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign alloc_idx  = any_free ? free_idx : victim_idx;
  assign lru_vld    = (state_q == LOOKUP && lu_hit) || (state_q == WALK && pt_hit);
  assign lru_idx    = (state_q == LOOKUP) ? lu_idx : alloc_idx;
  assign hit_cnt_d  = (hit_cnt_q  == 16'hFFFF) ? hit_cnt_q  : hit_cnt_q  + 16'd1;
  assign miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;

  tlb_lru #(.ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_lru (
    .clk        (clk),
    .rst_n      (rst_n),
    .access_vld (lru_vld),
    .access_idx (lru_idx),
    .victim_idx (victim_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      write_q      <= 1'b0;
      vaddr_q      <= '0;
      wdata_q      <= '0;
      valid_q      <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        tag_q[i] <= '0;
        ppn_q[i] <= '0;
      end
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_write_q  <= 1'b0;
      out_paddr_q  <= '0;
      out_wdata_q  <= '0;
      page_fault_q <= 1'b0;
      fault_vpn_q  <= '0;
    end else begin
      page_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tlb_flush) begin
            valid_q <= '0;
          end else if (req_valid) begin
            write_q <= req_write;
            vaddr_q <= req_vaddr;
            wdata_q <= req_wdata;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lu_hit) begin
            hit_cnt_q   <= hit_cnt_d;
            out_valid_q <= 1'b1;
            out_write_q <= write_q;
            out_paddr_q <= {ppn_q[lu_idx], offset};
            out_wdata_q <= wdata_q;
            state_q     <= ISSUE;
          end else begin
            miss_cnt_q <= miss_cnt_d;
            state_q    <= WALK;
          end
        end
        WALK: begin
          if (pt_hit) begin
            valid_q[alloc_idx] <= 1'b1;
            tag_q[alloc_idx]   <= vpn;
            ppn_q[alloc_idx]   <= pt_ppn;
            out_valid_q        <= 1'b1;
            out_write_q        <= write_q;
            out_paddr_q        <= {pt_ppn, offset};
            out_wdata_q        <= wdata_q;
            state_q            <= ISSUE;
          end else begin
            page_fault_q <= 1'b1;
            fault_vpn_q  <= vpn;
            state_q      <= FAULT;
          end
        end
        ISSUE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        FAULT:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !tlb_flush;
  assign pt_vpn     = vpn;
  assign out_valid  = out_valid_q;
  assign out_write  = out_write_q;
  assign out_paddr  = out_paddr_q;
  assign out_wdata  = out_wdata_q;
  assign page_fault = page_fault_q;
  assign fault_vpn  = fault_vpn_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_tlb_translator.sv
// Directed vector bench for tlb_translator: table of requests plus reset-state and reset-during-walk sequences.
module tb_tlb_translator;

  localparam int K_HIT = 0, K_MISS = 1, K_FAULT = 2;

  typedef struct {
    logic        flush;
    logic        wr;
    logic [13:0] vaddr;
    logic [31:0] wdata;
    logic        pth;
    logic [1:0]  ppn;
    int          kind;
    logic [9:0]  paddr;
    int          stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [13:0] req_vaddr = '0;
  logic [31:0] req_wdata = '0;
  logic        tlb_flush = 1'b0;
  logic [5:0]  pt_vpn;
  logic [1:0]  pt_ppn = '0;
  logic        pt_hit = 1'b0;
  logic        out_valid, out_ready = 1'b1, out_write;
  logic [9:0]  out_paddr;
  logic [31:0] out_wdata;
  logic        page_fault;
  logic [5:0]  fault_vpn;
  logic [15:0] hit_count, miss_count;

  int n_tests = 0, n_fail = 0;
  int exp_hits = 0, exp_miss = 0;
  vec_t vecs [17];

  always #5 clk = ~clk;

  tlb_translator #(.TLB_ENTRIES(4), .VPN_W(6), .PPN_W(2), .OFFSET_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_vaddr(req_vaddr), .req_wdata(req_wdata), .tlb_flush(tlb_flush),
    .pt_vpn(pt_vpn), .pt_ppn(pt_ppn), .pt_hit(pt_hit),
    .out_valid(out_valid), .out_ready(out_ready), .out_write(out_write),
    .out_paddr(out_paddr), .out_wdata(out_wdata),
    .page_fault(page_fault), .fault_vpn(fault_vpn),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input logic fl, input logic wr, input logic [13:0] va,
                              input logic [31:0] wd, input logic ph, input logic [1:0] pp,
                              input int kind, input logic [9:0] pa, input int stall);
    vec_t v;
    v.flush = fl; v.wr = wr; v.vaddr = va; v.wdata = wd; v.pth = ph; v.ppn = pp;
    v.kind = kind; v.paddr = pa; v.stall = stall;
    return v;
  endfunction

  task automatic run_req(input vec_t v, input string tag);
    int lat;
    if (v.flush) begin
      @(negedge clk);
      tlb_flush = 1'b1; req_valid = 1'b1; req_vaddr = v.vaddr;
      #1 check({tag, ".flush_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    tlb_flush = 1'b0; req_valid = 1'b1; req_write = v.wr; req_vaddr = v.vaddr;
    req_wdata = v.wdata; pt_hit = v.pth; pt_ppn = v.ppn;
    out_ready = (v.stall == 0);
    #1 check({tag, ".ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (lat < 10 && !out_valid && !page_fault);
    check({tag, ".latency"}, 32'(lat), (v.kind == K_HIT) ? 32'd2 : 32'd3);
    check({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
    check({tag, ".pt_vpn"}, 32'(pt_vpn), 32'(v.vaddr[13:8]));
    if (v.kind == K_FAULT) begin
      check({tag, ".fault"}, 32'(page_fault), 32'd1);
      check({tag, ".fault_vpn"}, 32'(fault_vpn), 32'(v.vaddr[13:8]));
      check({tag, ".no_out"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      check({tag, ".fault_pulse"}, 32'(page_fault), 32'd0);
      check({tag, ".no_out_after"}, 32'(out_valid), 32'd0);
    end else begin
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".no_fault"}, 32'(page_fault), 32'd0);
      check({tag, ".paddr"}, 32'(out_paddr), 32'(v.paddr));
      check({tag, ".write"}, 32'(out_write), 32'(v.wr));
      check({tag, ".wdata"}, out_wdata, v.wdata);
      for (int s = 0; s < v.stall; s++) begin
        tlb_flush = 1'b1;
        @(negedge clk);
        check({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".stall_paddr"}, 32'(out_paddr), 32'(v.paddr));
        check({tag, ".stall_wdata"}, out_wdata, v.wdata);
        check({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
      end
      tlb_flush = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check({tag, ".consumed"}, 32'(out_valid), 32'd0);
    end
    if (v.kind == K_HIT) exp_hits++;
    else exp_miss++;
    check({tag, ".hit_count"}, 32'(hit_count), 32'(exp_hits));
    check({tag, ".miss_count"}, 32'(miss_count), 32'(exp_miss));
  endtask

  initial begin
    int seen;
    //              fl  wr  vaddr     wdata         pth ppn kind    paddr    stall
    vecs[0]  = mk(0, 0, 14'h0134, 32'h0,        1, 2, K_MISS,  10'h234, 0);
    vecs[1]  = mk(0, 0, 14'h01FF, 32'h0,        0, 0, K_HIT,   10'h2FF, 0);
    vecs[2]  = mk(0, 1, 14'h0512, 32'hDEADBEEF, 0, 0, K_FAULT, 10'h000, 0);
    vecs[3]  = mk(0, 1, 14'h0512, 32'hCAFEF00D, 1, 3, K_MISS,  10'h312, 0);
    vecs[4]  = mk(1, 0, 14'h0010, 32'h0,        1, 1, K_MISS,  10'h110, 0);
    vecs[5]  = mk(0, 0, 14'h0120, 32'h0,        1, 0, K_MISS,  10'h020, 0);
    vecs[6]  = mk(0, 0, 14'h0230, 32'h0,        1, 3, K_MISS,  10'h330, 0);
    vecs[7]  = mk(0, 0, 14'h0340, 32'h0,        1, 2, K_MISS,  10'h240, 0);
    vecs[8]  = mk(0, 0, 14'h00AA, 32'h0,        0, 0, K_HIT,   10'h1AA, 0);
    vecs[9]  = mk(0, 0, 14'h0455, 32'h0,        1, 0, K_MISS,  10'h055, 0);
    vecs[10] = mk(0, 0, 14'h0366, 32'h0,        0, 0, K_HIT,   10'h266, 0);
    vecs[11] = mk(0, 0, 14'h0101, 32'h0,        1, 1, K_MISS,  10'h101, 0);
    vecs[12] = mk(0, 0, 14'h0077, 32'h0,        0, 0, K_HIT,   10'h177, 0);
    vecs[13] = mk(0, 0, 14'h0288, 32'h0,        1, 2, K_MISS,  10'h288, 0);
    vecs[14] = mk(0, 1, 14'h0277, 32'h12345678, 0, 0, K_HIT,   10'h277, 5);
    vecs[15] = mk(0, 0, 14'h0299, 32'h0,        0, 0, K_HIT,   10'h299, 0);
    vecs[16] = mk(1, 1, 14'h02AB, 32'hA5A5A5A5, 1, 1, K_MISS,  10'h1AB, 0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.page_fault", 32'(page_fault), 32'd0);
    check("rst.fault_vpn", 32'(fault_vpn), 32'd0);
    check("rst.paddr", 32'(out_paddr), 32'd0);
    check("rst.hit_count", 32'(hit_count), 32'd0);
    check("rst.miss_count", 32'(miss_count), 32'd0);
    rst_n = 1'b1;
    #1 check("rst.req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 17; i++) run_req(vecs[i], $sformatf("v%0d", i));

    // Reset asserted while the page walk is in progress
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_vaddr = 14'h0933; pt_hit = 1'b0; pt_ppn = 2'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("walk.pt_vpn", 32'(pt_vpn), 32'h9);
    check("walk.miss_count", 32'(miss_count), 32'(exp_miss + 1));
    rst_n = 1'b0;
    #1;
    check("wrst.out_valid", 32'(out_valid), 32'd0);
    check("wrst.page_fault", 32'(page_fault), 32'd0);
    check("wrst.fault_vpn", 32'(fault_vpn), 32'd0);
    check("wrst.paddr", 32'(out_paddr), 32'd0);
    check("wrst.wdata", out_wdata, 32'd0);
    check("wrst.write", 32'(out_write), 32'd0);
    check("wrst.miss_count", 32'(miss_count), 32'd0);
    check("wrst.hit_count", 32'(hit_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_hits = 0;
    exp_miss = 0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid || page_fault) seen++;
    end
    check("wrst.no_late_output", 32'(seen), 32'd0);
    check("wrst.req_ready", 32'(req_ready), 32'd1);
    run_req(mk(0, 0, 14'h0277, 32'h0, 1, 3, K_MISS, 10'h377, 0), "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
